aes_core_arbiter: RTL and testbench
===================================

AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter KEY_W, 256, key bus width.
REQ-002 Parameter BLK_W, 128, block/result width.
REQ-003 aes_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 aes_rst  in  1  asynchronous, active-high reset.
REQ-005 reqN_valid  in  1  (N=0,1) requester N has a block to encrypt.
REQ-006 reqN_ready  out  1  one-cycle accept pulse for requester N.
REQ-007 reqN_key  in  KEY_W  requester N key.
REQ-008 reqN_keylen  in  1  1=256-bit, 0=128-bit key.
REQ-009 reqN_encdec  in  1  1=encrypt, 0=decrypt.
REQ-010 reqN_block  in  BLK_W  input block.
REQ-011 key_flush  in  1  invalidate loaded-key record.
REQ-012 rsp_valid  out  1  one-cycle result pulse.
REQ-013 rsp_id  out  1  requester owning rsp_result.
REQ-014 rsp_result  out  BLK_W  result; held until next rsp_valid.
REQ-015 core_init, core_next  out  1  one-cycle pulses to core.
REQ-016 core_key, core_keylen, core_encdec, core_block  out  KEY_W/1/1/BLK_W  latched operands driven to core.
REQ-017 core_ready  in  1  core idle; core_result  in  BLK_W.

Function
REQ-018 FSM states IDLE, KEY_START, KEY_WAIT, BLK_START, BLK_WAIT, RESP.
REQ-019 IDLE: grant only when core_ready=1 and some reqN_valid=1; pulse reqN_ready same cycle; latch key, keylen, encdec, block, id.
REQ-020 Both valid: round-robin, grant requester not granted last; last_grant resets to 1 so req0 wins first tie.
REQ-021 Single valid: granted regardless of last_grant; last_grant updated on every grant.
REQ-022 Grant with key miss -> KEY_START; key hit (REQ-036) -> BLK_START.
REQ-023 KEY_START: pulse core_init one cycle, go KEY_WAIT.
REQ-024 KEY_WAIT: ignore core_ready first cycle; afterwards core_ready=1 -> BLK_START; record loaded key/keylen, set key_vld.
REQ-025 BLK_START: pulse core_next one cycle, go BLK_WAIT.
REQ-026 BLK_WAIT: ignore core_ready first cycle; afterwards core_ready=1 -> capture core_result, go RESP.
REQ-027 RESP: rsp_valid=1 one cycle with rsp_id, rsp_result; return IDLE; no grant in RESP.
REQ-028 core_init and core_next never high together, never high when core_ready=0.
REQ-029 Latency grant-to-rsp_valid = 2 + key-expansion cycles (miss only) + 2 + block cycles.
REQ-030 Requester inputs may change after reqN_ready; only latched copies drive the core.
REQ-031 key_flush clears key_vld same edge; if coincident with grant, grant is treated as miss.
REQ-032 Request withdrawn (valid dropped) before grant: no effect, no reqN_ready.

Reset
REQ-033 aes_rst asserted at any time, including mid-operation: state=IDLE, key_vld=0, last_grant=1, reqN_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, core_init=0, core_next=0, core_key/keylen/encdec/block=0.
REQ-034 In-flight transaction on reset is dropped; no rsp_valid is generated for it.

Configuration
REQ-035 Macro AES_ARB_KEY_CACHE_EN compiles key reuse in or out.
REQ-036 Defined: hit when key_vld=1 and latched key and keylen equal loaded key/keylen; hit skips KEY_START/KEY_WAIT.
REQ-037 Undefined: every grant is a miss; key_flush accepted but without effect.

Structure
REQ-038 Package aes_arb_pkg holds state enum, KEY_W/BLK_W defaults and requester-id type.
REQ-039 Sub-module aes_rr_arb2: 2-way round-robin grant logic with last_grant register.

Verification
REQ-040 Single req0, key 000102..1f, keylen=1, block 00112233445566778899aabbccddeeff -> one core_init, one core_next, rsp_id=0, rsp_result=8ea2b7ca516745bfeafc49904b496089.
REQ-041 req0 and req1 valid same cycle after reset -> req0 granted first, req1 second, rsp_id order 0 then 1.
REQ-042 Cache on: two back-to-back req0 with same key -> second has no core_init, latency shorter by key-expansion time; cache off -> both issue core_init.
REQ-043 key_flush pulse between two same-key requests -> second request issues core_init.
REQ-044 aes_rst asserted during BLK_WAIT -> all outputs at reset values next cycle, no rsp_valid; subsequent request completes correctly.
REQ-045 core_ready held 0 while req1 valid -> no reqN_ready until core_ready=1.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared types and defaults for the two-requester AES core arbiter.
package aes_arb_pkg;

  localparam int KEY_W_DEF = 256;
  localparam int BLK_W_DEF = 128;

  typedef logic req_id_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY_START,
    KEY_WAIT,
    BLK_START,
    BLK_WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Requester, response and core-side bundle for aes_core_arbiter.
interface aes_core_arbiter_if
  import aes_arb_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int BLK_W = BLK_W_DEF
);

  logic             req0_valid;
  logic             req0_ready;
  logic [KEY_W-1:0] req0_key;
  logic             req0_keylen;
  logic             req0_encdec;
  logic [BLK_W-1:0] req0_block;

  logic             req1_valid;
  logic             req1_ready;
  logic [KEY_W-1:0] req1_key;
  logic             req1_keylen;
  logic             req1_encdec;
  logic [BLK_W-1:0] req1_block;

  logic             key_flush;

  logic             rsp_valid;
  req_id_t          rsp_id;
  logic [BLK_W-1:0] rsp_result;

  logic             core_init;
  logic             core_next;
  logic [KEY_W-1:0] core_key;
  logic             core_keylen;
  logic             core_encdec;
  logic [BLK_W-1:0] core_block;
  logic             core_ready;
  logic [BLK_W-1:0] core_result;

  // master = the arbiter, slave = requesters plus core
  modport master (
    input  req0_valid, req0_key, req0_keylen, req0_encdec, req0_block,
    input  req1_valid, req1_key, req1_keylen, req1_encdec, req1_block,
    input  key_flush, core_ready, core_result,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result,
    output core_init, core_next, core_key, core_keylen, core_encdec, core_block
  );

  modport slave (
    output req0_valid, req0_key, req0_keylen, req0_encdec, req0_block,
    output req1_valid, req1_key, req1_keylen, req1_encdec, req1_block,
    output key_flush, core_ready, core_result,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result,
    input  core_init, core_next, core_key, core_keylen, core_encdec, core_block
  );

endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins the first tie.
module aes_rr_arb2
  import aes_arb_pkg::*;
(
  input  logic       aes_clk,
  input  logic       aes_rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);

  req_id_t last_grant_reg;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) gnt_id = ~last_grant_reg;
    else                  gnt_id = req[1];
    if (en) gnt[gnt_id] = |req;
  end

  always_ff @(posedge aes_clk or posedge aes_rst) begin
    if (aes_rst)            last_grant_reg <= 1'b1;
    else if (en && |req)    last_grant_reg <= gnt_id;
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between two requesters; define AES_ARB_KEY_CACHE_EN to skip
// key expansion when the granted key/keylen match the key already loaded in the core.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int BLK_W = BLK_W_DEF
) (
  input logic                aes_clk,
  input logic                aes_rst,
  aes_core_arbiter_if.master bus
);

  arb_state_t       state_reg;
  logic             wait_first_reg;
  req_id_t          cur_id_reg;
  logic [KEY_W-1:0] key_reg;
  logic             keylen_reg;
  logic             encdec_reg;
  logic [BLK_W-1:0] block_reg;
  logic             rsp_valid_reg;
  req_id_t          rsp_id_reg;
  logic [BLK_W-1:0] rsp_result_reg;
  logic             core_init_reg;
  logic             core_next_reg;

  logic             grant_en;
  logic [1:0]       req_valid;
  logic [1:0]       req_gnt;
  req_id_t          gnt_id;
  logic [KEY_W-1:0] sel_key;
  logic             sel_keylen;
  logic             sel_encdec;
  logic [BLK_W-1:0] sel_block;
  logic             key_hit;
  logic             core_done;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  // Reset gating keeps the combinational accept pulses low while aes_rst is held
  assign grant_en  = (state_reg == IDLE) && bus.core_ready && !aes_rst;
  // The core drops core_ready one cycle after a start pulse, so the first wait cycle is skipped
  assign core_done = !wait_first_reg && bus.core_ready;

  aes_rr_arb2 u_rr_arb (
    .aes_clk (aes_clk),
    .aes_rst (aes_rst),
    .en      (grant_en),
    .req     (req_valid),
    .gnt     (req_gnt),
    .gnt_id  (gnt_id)
  );

  assign sel_key    = gnt_id ? bus.req1_key    : bus.req0_key;
  assign sel_keylen = gnt_id ? bus.req1_keylen : bus.req0_keylen;
  assign sel_encdec = gnt_id ? bus.req1_encdec : bus.req0_encdec;
  assign sel_block  = gnt_id ? bus.req1_block  : bus.req0_block;

`ifdef AES_ARB_KEY_CACHE_EN
  logic             key_vld_reg;
  logic [KEY_W-1:0] loaded_key_reg;
  logic             loaded_keylen_reg;

  // A flush on the grant edge forces a miss
  assign key_hit = key_vld_reg && !bus.key_flush &&
                   (sel_key == loaded_key_reg) && (sel_keylen == loaded_keylen_reg);

  always_ff @(posedge aes_clk or posedge aes_rst) begin
    if (aes_rst) begin
      key_vld_reg       <= 1'b0;
      loaded_key_reg    <= '0;
      loaded_keylen_reg <= 1'b0;
    end else if (bus.key_flush) begin
      key_vld_reg <= 1'b0;
    end else if (state_reg == KEY_WAIT && core_done) begin
      key_vld_reg       <= 1'b1;
      loaded_key_reg    <= key_reg;
      loaded_keylen_reg <= keylen_reg;
    end
  end
`else
  logic unused_key_flush;
  assign unused_key_flush = bus.key_flush;
  assign key_hit          = 1'b0;
`endif

  always_ff @(posedge aes_clk or posedge aes_rst) begin
    if (aes_rst) begin
      state_reg      <= IDLE;
      wait_first_reg <= 1'b0;
      cur_id_reg     <= 1'b0;
      key_reg        <= '0;
      keylen_reg     <= 1'b0;
      encdec_reg     <= 1'b0;
      block_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      core_init_reg  <= 1'b0;
      core_next_reg  <= 1'b0;
    end else begin
      core_init_reg <= 1'b0;
      core_next_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req_gnt) begin
            cur_id_reg    <= gnt_id;
            key_reg       <= sel_key;
            keylen_reg    <= sel_keylen;
            encdec_reg    <= sel_encdec;
            block_reg     <= sel_block;
            state_reg     <= key_hit ? BLK_START : KEY_START;
            core_init_reg <= !key_hit;
            core_next_reg <= key_hit;
          end
        end
        KEY_START: begin
          state_reg      <= KEY_WAIT;
          wait_first_reg <= 1'b1;
        end
        KEY_WAIT: begin
          wait_first_reg <= 1'b0;
          if (core_done) begin
            state_reg     <= BLK_START;
            core_next_reg <= 1'b1;
          end
        end
        BLK_START: begin
          state_reg      <= BLK_WAIT;
          wait_first_reg <= 1'b1;
        end
        BLK_WAIT: begin
          wait_first_reg <= 1'b0;
          if (core_done) begin
            rsp_result_reg <= bus.core_result;
            rsp_id_reg     <= cur_id_reg;
            rsp_valid_reg  <= 1'b1;
            state_reg      <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = req_gnt[0];
  assign bus.req1_ready  = req_gnt[1];
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_id      = rsp_id_reg;
  assign bus.rsp_result  = rsp_result_reg;
  assign bus.core_init   = core_init_reg;
  assign bus.core_next   = core_next_reg;
  assign bus.core_key    = key_reg;
  assign bus.core_keylen = keylen_reg;
  assign bus.core_encdec = encdec_reg;
  assign bus.core_block  = block_reg;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a behavioural AES core stand-in.
module tb_aes_core_arbiter;
  import aes_arb_pkg::*;

  localparam int KEY_CYC = 6;
  localparam int BLK_CYC = 4;
  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_BLK = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_RES = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_A   = {128'h1, 128'h2};
`ifdef AES_ARB_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic aes_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 aes_clk = ~aes_clk;

  aes_core_arbiter_if #(.KEY_W(256), .BLK_W(128)) bus ();

  aes_core_arbiter #(.KEY_W(256), .BLK_W(128)) dut (
    .aes_clk (aes_clk),
    .aes_rst (rst),
    .bus     (bus)
  );

  // Core stand-in: busy for KEY_CYC after init, BLK_CYC after next
  logic         core_rdy_q;
  logic         core_hold = 1'b0;
  logic [127:0] core_res_q;
  int           busy_cnt;
  int           init_cnt;
  int           next_cnt;
  int           viol;
  int           cyc;

  assign bus.core_ready  = core_rdy_q & ~core_hold;
  assign bus.core_result = core_res_q;

  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic kl,
                                           input logic ed, input logic [127:0] b);
    if (k == KAT_KEY && kl && ed && b == KAT_BLK) return KAT_RES;
    return b ^ k[127:0] ^ k[255:128];
  endfunction

  always @(posedge aes_clk or posedge rst) begin
    if (rst) begin
      core_rdy_q <= 1'b1;
      busy_cnt   <= 0;
      core_res_q <= '0;
    end else if (bus.core_init) begin
      core_rdy_q <= 1'b0;
      busy_cnt   <= KEY_CYC;
      init_cnt   <= init_cnt + 1;
    end else if (bus.core_next) begin
      core_rdy_q <= 1'b0;
      busy_cnt   <= BLK_CYC;
      next_cnt   <= next_cnt + 1;
      core_res_q <= core_fn(bus.core_key, bus.core_keylen, bus.core_encdec, bus.core_block);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) core_rdy_q <= 1'b1;
    end
  end

  always @(posedge aes_clk) cyc <= cyc + 1;

  always @(negedge aes_clk)
    if (!rst && ((bus.core_init && bus.core_next) ||
                 ((bus.core_init || bus.core_next) && !bus.core_ready)))
      viol <= viol + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int           gnt_q[$];
  int           gnt_cyc_q[$];
  int           rsp_id_q[$];
  logic [127:0] rsp_res_q[$];
  int           rsp_cyc_q[$];
  bit           drop0, drop1;

  task automatic clear_q();
    gnt_q.delete(); gnt_cyc_q.delete();
    rsp_id_q.delete(); rsp_res_q.delete(); rsp_cyc_q.delete();
  endtask

  // Accepted requests are withdrawn and their operands scrambled on the following cycle
  task automatic step_begin();
    @(negedge aes_clk);
    if (drop0) begin
      bus.req0_valid = 1'b0; bus.req0_key = '1; bus.req0_block = '0;
      bus.req0_keylen = 1'b0; bus.req0_encdec = 1'b0; drop0 = 1'b0;
    end
    if (drop1) begin
      bus.req1_valid = 1'b0; bus.req1_key = '1; bus.req1_block = '0;
      bus.req1_keylen = 1'b0; bus.req1_encdec = 1'b0; drop1 = 1'b0;
    end
  endtask

  task automatic step_end();
    #1;
    if (bus.req0_valid && bus.req0_ready) begin
      gnt_q.push_back(0); gnt_cyc_q.push_back(cyc); drop0 = 1'b1;
    end
    if (bus.req1_valid && bus.req1_ready) begin
      gnt_q.push_back(1); gnt_cyc_q.push_back(cyc); drop1 = 1'b1;
    end
    if (bus.rsp_valid) begin
      rsp_id_q.push_back(int'(bus.rsp_id));
      rsp_res_q.push_back(bus.rsp_result);
      rsp_cyc_q.push_back(cyc);
      $display("txn rsp id=%0d result=%h cycle=%0d", bus.rsp_id, bus.rsp_result, cyc);
    end
  endtask

  task automatic step();
    step_begin();
    step_end();
  endtask

  task automatic issue(input int id, input logic [255:0] k, input logic kl,
                       input logic ed, input logic [127:0] b);
    if (id == 0) begin
      bus.req0_key = k; bus.req0_keylen = kl; bus.req0_encdec = ed;
      bus.req0_block = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_key = k; bus.req1_keylen = kl; bus.req1_encdec = ed;
      bus.req1_block = b; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && rsp_id_q.size() < n; i++) step();
    check("rsp_count", rsp_id_q.size(), n);
  endtask

  task automatic do_reset();
    step_begin();
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drop0 = 1'b0; drop1 = 1'b0;
    step_end();
    repeat (2) step();
    step_begin(); rst = 1'b0; step_end();
  endtask

  initial begin
    int i0, i1, n0, lat1, lat2;
    bus.req0_valid = 1'b1; bus.req0_key = '0; bus.req0_keylen = 1'b0;
    bus.req0_encdec = 1'b0; bus.req0_block = '0;
    bus.req1_valid = 1'b0; bus.req1_key = '0; bus.req1_keylen = 1'b0;
    bus.req1_encdec = 1'b0; bus.req1_block = '0;
    bus.key_flush = 1'b0;
    init_cnt = 0; next_cnt = 0; viol = 0; cyc = 0;

    // Reset state, with req0_valid held high during reset
    repeat (2) @(negedge aes_clk);
    #1;
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_core_init", bus.core_init, 0);
    check("rst_core_next", bus.core_next, 0);
    check("rst_core_key", bus.core_key, 0);
    check("rst_core_block", bus.core_block, 0);
    bus.req0_valid = 1'b0;
    step_begin(); rst = 1'b0; step_end();

    // Known-answer transaction from requester 0
    clear_q();
    i0 = init_cnt; n0 = next_cnt;
    step_begin(); issue(0, KAT_KEY, 1'b1, 1'b1, KAT_BLK); step_end();
    wait_rsp(1, 100);
    check("kat_init_cnt", init_cnt - i0, 1);
    check("kat_next_cnt", next_cnt - n0, 1);
    check("kat_rsp_id", rsp_id_q[0], 0);
    check("kat_result", rsp_res_q[0], KAT_RES);

    // Simultaneous requests right after reset: req0 first, then req1
    do_reset();
    clear_q();
    step_begin();
    issue(0, 256'h0, 1'b1, 1'b1, 128'h1234);
    issue(1, 256'hff00, 1'b1, 1'b1, 128'h00ff);
    step_end();
    wait_rsp(2, 200);
    check("rr_first_gnt", gnt_q[0], 0);
    check("rr_second_gnt", gnt_q[1], 1);
    check("rr_rsp_id0", rsp_id_q[0], 0);
    check("rr_rsp_id1", rsp_id_q[1], 1);
    check("rr_result0", rsp_res_q[0], 128'h1234);
    check("rr_result1", rsp_res_q[1], 128'hffff);

    // Same key twice from requester 0
    do_reset();
    clear_q();
    step_begin(); issue(0, KEY_A, 1'b1, 1'b1, 128'h10); step_end();
    wait_rsp(1, 100);
    i0 = init_cnt;
    step_begin(); issue(0, KEY_A, 1'b1, 1'b1, 128'h20); step_end();
    wait_rsp(2, 100);
    i1 = init_cnt;
    lat1 = rsp_cyc_q[0] - gnt_cyc_q[0];
    lat2 = rsp_cyc_q[1] - gnt_cyc_q[1];
    check("reuse_result1", rsp_res_q[0], 128'h13);
    check("reuse_result2", rsp_res_q[1], 128'h23);
    check("reuse_init_cnt", i1 - i0, CACHE_ON ? 0 : 1);
    check("reuse_lat_diff", lat1 - lat2, CACHE_ON ? KEY_CYC + 2 : 0);

    // key_flush pulse between two same-key requests
    step_begin(); bus.key_flush = 1'b1; step_end();
    step_begin(); bus.key_flush = 1'b0; step_end();
    i0 = init_cnt;
    step_begin(); issue(0, KEY_A, 1'b1, 1'b1, 128'h30); step_end();
    wait_rsp(3, 100);
    check("flush_init_cnt", init_cnt - i0, 1);
    check("flush_result", rsp_res_q[2], 128'h33);

    // key_flush coincident with the grant
    i0 = init_cnt;
    step_begin(); issue(0, KEY_A, 1'b1, 1'b1, 128'h40); bus.key_flush = 1'b1; step_end();
    step_begin(); bus.key_flush = 1'b0; step_end();
    wait_rsp(4, 100);
    check("flush_gnt_init_cnt", init_cnt - i0, 1);

    // Core busy: no accept while core_ready is low
    clear_q();
    step_begin(); core_hold = 1'b1; issue(1, 256'h0, 1'b0, 1'b0, 128'h55); step_end();
    repeat (5) step();
    check("hold_no_ready", gnt_q.size(), 0);
    step_begin(); core_hold = 1'b0; step_end();
    check("hold_release_gnt", gnt_q.size(), 1);
    wait_rsp(1, 100);
    check("hold_rsp_id", rsp_id_q[0], 1);
    check("hold_result", rsp_res_q[0], 128'h55);

    // Reset during BLK_WAIT drops the transaction
    clear_q();
    step_begin(); issue(0, KEY_A, 1'b1, 1'b1, 128'h77); step_end();
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.core_next) break;
    end
    check("mid_saw_core_next", bus.core_next, 1);
    repeat (2) step();
    step_begin(); rst = 1'b1; step_end();
    check("mid_rsp_valid", bus.rsp_valid, 0);
    check("mid_rsp_id", bus.rsp_id, 0);
    check("mid_rsp_result", bus.rsp_result, 0);
    check("mid_core_init", bus.core_init, 0);
    check("mid_core_next", bus.core_next, 0);
    check("mid_core_key", bus.core_key, 0);
    check("mid_core_block", bus.core_block, 0);
    check("mid_core_keylen", bus.core_keylen, 0);
    check("mid_core_encdec", bus.core_encdec, 0);
    step_begin(); rst = 1'b0; step_end();
    repeat (20) step();
    check("mid_no_rsp", rsp_id_q.size(), 0);
    step_begin(); issue(0, KEY_A, 1'b1, 1'b1, 128'h50); step_end();
    wait_rsp(1, 100);
    check("mid_after_id", rsp_id_q[0], 0);
    check("mid_after_result", rsp_res_q[0], 128'h53);

    check("init_next_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
